display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DWELL, default 1: clock cycles each digit is lit, legal range >=1.
REQ-003 Parameter GUARD, default 1: all-anodes-off cycles between digits (anti-ghosting), legal range >=0.
REQ-004 Parameter ANODE_ACTIVE_LOW, default 1: 1 means asserted anode = 0.
REQ-005 clk1kHz  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  scan run; low = freeze scan, anodes off.
REQ-008 bcd_in  in  4*N_DIGITS  digit values; bits [4i+3:4i] = digit i; digit 0 = least significant.
REQ-009 dp_in  in  N_DIGITS  decimal-point request per digit.
REQ-010 lz_blank  in  1  leading-zero blanking enable.
REQ-011 anode  out  N_DIGITS  digit select, one-hot or none, polarity per ANODE_ACTIVE_LOW.
REQ-012 segments  out  7  {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-013 dp  out  1  decimal point, active-low.
REQ-014 digit_idx  out  max(1,clog2(N_DIGITS))  index of digit currently selected.

Function
REQ-015 FSM states: SHOW (one anode asserted) and GAP (no anode asserted, segments all off).
REQ-016 In SHOW, the dwell counter counts 0..DWELL-1; at DWELL-1, go to GAP if GUARD>0, else stay in SHOW with digit_idx advanced.
REQ-017 In GAP, the guard counter counts 0..GUARD-1; at GUARD-1, go to SHOW with digit_idx advanced.
REQ-018 digit_idx advances by 1 and wraps from N_DIGITS-1 to 0; it never takes a value >= N_DIGITS.
REQ-019 Every digit is lit exactly DWELL cycles per frame; frame period = N_DIGITS*(DWELL+GUARD) cycles.
REQ-020 bcd_in, dp_in, and lz_blank are captured into a shadow register on the cycle digit_idx becomes 0; one frame always shows a single coherent snapshot.
REQ-021 Decode: values 0-9 map to standard 7-seg patterns; values 10-15 display a dash (only g lit).
REQ-022 Leading-zero blanking: for digit i>0, if the shadow lz_blank=1 and all shadow digits N_DIGITS-1..i equal 0, the digit's segments are off; digit 0 is never blanked.
REQ-023 dp is lit only in SHOW when the shadow dp bit for digit_idx is 1; blanking does not suppress dp.
REQ-024 All outputs are registered; anode, segments, and dp change together on the same edge.
REQ-025 While enable=0: anodes deasserted, segments/dp off, counters and state hold; when enable returns to 1, the scan resumes from the held state without skipping or repeating a cycle.
REQ-026 An input change in mid-frame has no visible effect until the next frame boundary.

Reset
REQ-027 On reset assertion, without waiting for a clock: state=SHOW, digit_idx=0, counters=0, shadow=0, anode deasserted, segments=7'b1111111, dp=1.
REQ-028 On the first enabled edge after reset, the block captures the shadow and lights digit 0; a reset during any state or count returns to REQ-027 values.

Structure
REQ-029 A shared package holds the 7-seg pattern constants (digits 0-9, DASH, OFF) and the index-width function.
REQ-030 The BCD-to-7-seg decoder is a separate combinational sub-module, bcd_to_7seg; the scan FSM and counters stay in display_scanner.

Verification
REQ-031 N=4, DWELL=1, GUARD=0, bcd=0x1234, lz=0: anode sequence 1110,1101,1011,0111 repeats every 4 cycles; segments show 4,3,2,1.
REQ-032 N=4, DWELL=3, GUARD=1: each anode is low for exactly 3 cycles, followed by 1 cycle with all anodes high; period = 16 cycles.
REQ-033 bcd=0x0050, lz=1: digits 3 and 2 are blank; digit 1 shows 5; digit 0 shows 0. bcd=0x0000 shows only digit 0 as 0.
REQ-034 bcd changes 0x1111 to 0x2222 while digit_idx=2: digits 2 and 3 still show 1; the next frame shows all 2s. Digit 0xA shows a dash.
REQ-035 Assert reset during GAP and again at digit_idx=3: outputs immediately reach REQ-027 values; digit_idx never exceeds N-1 (assertion over 10k cycles).
REQ-036 enable is low for 5 cycles in mid-dwell: anodes are off; after resume, the remaining dwell count is completed exactly.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: scan states,
// active-low segment patterns {g,f,e,d,c,b,a} and the index-width helper.
package display_scanner_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scanner_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; 10-15 render as a dash.
module bcd_to_7seg
  import display_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: SHOW/GAP FSM with dwell and guard counters,
// per-frame input snapshot, leading-zero blanking and fully registered outputs.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int N_DIGITS         = 4,
  parameter int DWELL            = 1,
  parameter int GUARD            = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                                 clk1kHz,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [4*N_DIGITS-1:0]                bcd_in,
  input  logic [N_DIGITS-1:0]                  dp_in,
  input  logic                                 lz_blank,
  output logic [N_DIGITS-1:0]                  anode,
  output logic [6:0]                           segments,
  output logic                                 dp,
  output logic [idx_width(N_DIGITS)-1:0]       digit_idx
);

  localparam int IDX_W   = idx_width(N_DIGITS);
  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CNT_W   = idx_width(CNT_MAX);

  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]    GUARD_LAST = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_e             state_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [4*N_DIGITS-1:0]   sh_bcd_q, view_bcd;
  logic [N_DIGITS-1:0]     sh_dp_q, view_dp;
  logic                    sh_lz_q, view_lz;
  logic                    capture;
  logic                    all_zero;
  logic [3:0]              cur_val;
  logic                    cur_blank;
  logic [6:0]              seg_dec;
  logic [N_DIGITS-1:0]     sel_onehot, anode_on;

  logic [N_DIGITS-1:0]     anode_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [IDX_W-1:0]        digit_idx_q;

  // The snapshot is taken on the first cycle of a frame, and that very cycle
  // already displays from the fresh values rather than the stale shadow.
  always_comb begin
    capture  = (state_q == SHOW) && (idx_q == '0) && (cnt_q == '0);
    view_bcd = capture ? bcd_in   : sh_bcd_q;
    view_dp  = capture ? dp_in    : sh_dp_q;
    view_lz  = capture ? lz_blank : sh_lz_q;

    cur_val   = view_bcd[{idx_q, 2'b00} +: 4];
    all_zero  = 1'b1;
    cur_blank = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (view_bcd[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        cur_blank = view_lz && all_zero;
      end
    end

    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    sel_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    anode_on   = (ANODE_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
  end

  bcd_to_7seg u_dec (
    .bcd_i   (cur_val),
    .blank_i (cur_blank),
    .seg_o   (seg_dec)
  );

  always_ff @(posedge clk1kHz or posedge reset) begin
    if (reset) begin
      state_q     <= SHOW;
      idx_q       <= '0;
      cnt_q       <= '0;
      sh_bcd_q    <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      anode_q     <= ANODE_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      digit_idx_q <= '0;
    end else if (!enable) begin
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      if (capture) begin
        sh_bcd_q <= bcd_in;
        sh_dp_q  <= dp_in;
        sh_lz_q  <= lz_blank;
      end
      digit_idx_q <= idx_q;
      if (state_q == SHOW) begin
        anode_q <= anode_on;
        seg_q   <= seg_dec;
        dp_q    <= ~view_dp[idx_q];
        if (cnt_q == DWELL_LAST) begin
          cnt_q <= '0;
          if (GUARD > 0) state_q <= GAP;
          else           idx_q   <= idx_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        anode_q <= ANODE_OFF;
        seg_q   <= SEG_OFF;
        dp_q    <= 1'b1;
        if (cnt_q == GUARD_LAST) begin
          cnt_q   <= '0;
          state_q <= SHOW;
          idx_q   <= idx_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign anode     = anode_q;
  assign segments  = seg_q;
  assign dp        = dp_q;
  assign digit_idx = digit_idx_q;

endmodule
